// File: rtl/pc_gen_btb_if.sv
// Fetch-PC generator bus: stall/redirect control, BTB training and IF-stage outputs.
//   en_i / redirect_i / redirect_pc_i             : PC advance, stall and EX redirect
//   upd_valid_i / upd_pc_i / upd_target_i / upd_taken_i : resolved-branch training
//   pc_o / pc4_o / pred_taken_o / pred_target_o   : fetch PC and next-PC prediction
// slave = the PC generator, master = the pipeline driving it.
interface pc_gen_btb_if #(
  parameter int unsigned XLEN = 32
);
  logic            en_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            upd_valid_i;
  logic [XLEN-1:0] upd_pc_i;
  logic [XLEN-1:0] upd_target_i;
  logic            upd_taken_i;
  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] pc4_o;
  logic            pred_taken_o;
  logic [XLEN-1:0] pred_target_o;

  modport master (
    output en_i, redirect_i, redirect_pc_i,
    output upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i,
    input  pc_o, pc4_o, pred_taken_o, pred_target_o
  );

  modport slave (
    input  en_i, redirect_i, redirect_pc_i,
    input  upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i,
    output pc_o, pc4_o, pred_taken_o, pred_target_o
  );
endinterface

// File: rtl/pc_gen_btb.sv
// Fetch-PC generator with a direct-mapped branch target buffer.
// Ports:
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   bus     : pc_gen_btb_if.slave (control, BTB training, fetch PC / prediction)
// pc_o is registered; pc4_o, pred_taken_o and pred_target_o are combinational on pc_o.
module pc_gen_btb #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     BTB_DEPTH = 16,
  parameter bit              BTB_EN    = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  pc_gen_btb_if.slave  bus
);

  localparam int unsigned IDXW = $clog2(BTB_DEPTH);
  localparam int unsigned TAGW = XLEN - IDXW - 2;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc4_c;
  logic            pred_taken_c;
  logic [XLEN-1:0] pred_target_c;

  // Word-alignment bits of incoming addresses are discarded by design.
  logic unused_align;
  assign unused_align = ^{bus.redirect_pc_i[1:0], bus.upd_target_i[1:0]};

  assign pc4_c = pc_q + XLEN'(4);

  // Next PC: redirect beats stall, stall beats prediction.
  always_comb begin
    pc_d = pc_q;
    if (bus.redirect_i) begin
      pc_d = {bus.redirect_pc_i[XLEN-1:2], 2'b00};
    end else if (bus.en_i) begin
      pc_d = pred_target_c;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  if (BTB_EN) begin : g_btb
    logic [BTB_DEPTH-1:0] valid_q;
    logic [TAGW-1:0]      tag_q [BTB_DEPTH];
    logic [XLEN-3:0]      tgt_q [BTB_DEPTH];
    logic [1:0]           ctr_q [BTB_DEPTH];

    logic [IDXW-1:0] lk_idx;
    logic [TAGW-1:0] lk_tag;
    logic            lk_hit;
    logic [IDXW-1:0] up_idx;
    logic [TAGW-1:0] up_tag;
    logic            up_hit;

    // Lookup reads the pre-update contents; no write-to-read bypass.
    assign lk_idx = pc_q[IDXW+1:2];
    assign lk_tag = pc_q[XLEN-1:IDXW+2];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    assign up_idx = bus.upd_pc_i[IDXW+1:2];
    assign up_tag = bus.upd_pc_i[XLEN-1:IDXW+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    assign pred_taken_c  = lk_hit && ctr_q[lk_idx][1];
    assign pred_target_c = pred_taken_c ? {tgt_q[lk_idx], 2'b00} : pc4_c;

    // Training: saturating counter on hit, allocate-on-taken on miss.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        valid_q <= '0;
        for (int unsigned i = 0; i < BTB_DEPTH; i++) begin
          tag_q[IDXW'(i)] <= '0;
          tgt_q[IDXW'(i)] <= '0;
          ctr_q[IDXW'(i)] <= 2'b01;
        end
      end else if (bus.upd_valid_i) begin
        if (up_hit) begin
          if (bus.upd_taken_i) begin
            if (ctr_q[up_idx] != 2'b11) begin
              ctr_q[up_idx] <= ctr_q[up_idx] + 2'd1;
            end
            tgt_q[up_idx] <= bus.upd_target_i[XLEN-1:2];
          end else if (ctr_q[up_idx] != 2'b00) begin
            ctr_q[up_idx] <= ctr_q[up_idx] - 2'd1;
          end
        end else if (bus.upd_taken_i) begin
          valid_q[up_idx] <= 1'b1;
          tag_q[up_idx]   <= up_tag;
          tgt_q[up_idx]   <= bus.upd_target_i[XLEN-1:2];
          ctr_q[up_idx]   <= 2'b10;
        end
      end
    end
  end else begin : g_no_btb
    // Without a BTB the training port has no effect.
    logic unused_upd;
    assign unused_upd    = ^{bus.upd_valid_i, bus.upd_pc_i, bus.upd_target_i, bus.upd_taken_i};
    assign pred_taken_c  = 1'b0;
    assign pred_target_c = pc4_c;
  end

  assign bus.pc_o          = pc_q;
  assign bus.pc4_o         = pc4_c;
  assign bus.pred_taken_o  = pred_taken_c;
  assign bus.pred_target_o = pred_target_c;

endmodule
